// File: rtl/memory_stage.sv
// memory_stage -- pipeline stage after execute.
//
// Runs ARM single data transfers (LDR/STR: word or byte, pre/post-index,
// up/down, base writeback) over a simple req/ready data bus. Upstream is
// stalled while an access is outstanding. Non-memory instructions and their
// register writes are forwarded to writeback one cycle later.
//
// Build option: define MEMORY_ROTATE_EN to return unaligned word loads
// rotated right by 8*addr[1:0]. Without it, word load data is returned as
// read. Word accesses always drive bus_addr[1:0] = 00 in both builds.
//
// Parameters
//   ADDR_W  data bus address width (<= 32). The computed address is
//           truncated to this width.
//
// Ports
//   clk, Nrst              clock, asynchronous active-low reset
//   stall, flush           downstream stall (hold outputs), kill this stage
//   inbubble, pc, insn     incoming slot from execute
//   op0, op1, op2          base Rn, offset, store data Rd
//   write_reg/num/data     register write pending from execute
//   outstall               stall to upstream stages (combinational)
//   outbubble, outpc, outinsn
//   out_write_reg/num/data primary register write (load result or forwarded)
//   out_base_wr/num/data   base register writeback
//   bus_req, bus_wr, bus_addr, bus_wdata, bus_be   registered bus request
//   bus_ready, bus_rdata   bus handshake and load data
module memory_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              Nrst,
  input  logic              stall,
  input  logic              flush,
  input  logic              inbubble,
  input  logic [31:0]       pc,
  input  logic [31:0]       insn,
  input  logic [31:0]       op0,
  input  logic [31:0]       op1,
  input  logic [31:0]       op2,
  input  logic              write_reg,
  input  logic [3:0]        write_num,
  input  logic [31:0]       write_data,
  output logic              outstall,
  output logic              outbubble,
  output logic              out_write_reg,
  output logic [3:0]        out_write_num,
  output logic [31:0]       out_write_data,
  output logic              out_base_wr,
  output logic [3:0]        out_base_num,
  output logic [31:0]       out_base_data,
  output logic [31:0]       outpc,
  output logic [31:0]       outinsn,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state_q, state_d;

  // Shift right by whole bytes; with MEMORY_ROTATE_EN the bytes shifted out
  // come back in at the top.
  function automatic logic [31:0] load_format(input logic [31:0] d,
                                              input logic [1:0]  lane,
                                              input logic        is_byte);
    logic [31:0] sh;
    sh = d >> {lane, 3'b000};
    if (is_byte) begin
      return {24'h000000, sh[7:0]};
    end
`ifdef MEMORY_ROTATE_EN
    // Shifting by 32 gives zero, so lane 0 returns d unchanged.
    return sh | (d << (6'd32 - {1'b0, lane, 3'b000}));
`else
    return d;
`endif
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] lane,
                                              input logic       is_byte);
    return is_byte ? (4'b0001 << lane) : 4'b1111;
  endfunction

  // Decode and address generation on the incoming slot
  logic        is_mem;
  logic        mem_go;
  logic [31:0] off_addr;
  logic [31:0] acc_addr;
  logic [31:0] bus_addr_full;
  logic        base_wb;
  logic        f_p, f_u, f_b, f_w, f_l;

  assign f_p = insn[24];
  assign f_u = insn[23];
  assign f_b = insn[22];
  assign f_w = insn[21];
  assign f_l = insn[20];

  // insn[25] & insn[4] is the register-shifted/media space, not a transfer.
  assign is_mem   = (insn[27:26] == 2'b01) && !(insn[25] && insn[4]);
  assign mem_go   = is_mem && !inbubble && !flush;
  assign off_addr = f_u ? (op0 + op1) : (op0 - op1);
  assign acc_addr = f_p ? off_addr : op0;
  assign bus_addr_full = f_b ? acc_addr : {acc_addr[31:2], 2'b00};
  // A load into its own base register keeps the loaded value.
  assign base_wb  = (!f_p || f_w) && !(f_l && (insn[15:12] == insn[19:16]));

  // Context of the access in flight, captured when it leaves IDLE
  logic [31:0] pc_p0;
  logic [31:0] insn_p0;
  logic        ld_p0;
  logic        byte_p0;
  logic [1:0]  lane_p0;
  logic [3:0]  rd_p0;
  logic [3:0]  rn_p0;
  logic        base_wb_p0;
  logic [31:0] base_data_p0;
  logic [31:0] rdata_p1;
  logic        kill_p0;

  logic        cap_ctx;
  logic        bus_done;
  logic        out_ld;
  logic        kill;

  logic        nxt_bubble;
  logic        nxt_wr;
  logic [3:0]  nxt_wnum;
  logic [31:0] nxt_wdata;
  logic        nxt_bwr;
  logic [3:0]  nxt_bnum;
  logic [31:0] nxt_bdata;
  logic [31:0] nxt_pc;
  logic [31:0] nxt_insn;

  assign bus_done = (state_q == BUSY) && bus_ready;
  assign kill     = kill_p0 || flush;

  always_comb begin
    state_d    = state_q;
    outstall   = stall;
    cap_ctx    = 1'b0;
    out_ld     = !stall;
    // Default output slot is a bubble
    nxt_bubble = 1'b1;
    nxt_wr     = 1'b0;
    nxt_wnum   = write_num;
    nxt_wdata  = write_data;
    nxt_bwr    = 1'b0;
    nxt_bnum   = 4'h0;
    nxt_bdata  = 32'h0;
    nxt_pc     = pc;
    nxt_insn   = insn;
    unique case (state_q)
      IDLE: begin
        if (mem_go) begin
          outstall = 1'b1;
          cap_ctx  = 1'b1;
          state_d  = BUSY;
        end else begin
          nxt_bubble = inbubble || flush;
          nxt_wr     = write_reg && !inbubble && !flush;
        end
      end
      BUSY: begin
        outstall = 1'b1;
        if (bus_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!stall) begin
          state_d    = IDLE;
          nxt_bubble = kill;
          nxt_wr     = ld_p0 && !kill;
          nxt_wnum   = rd_p0;
          nxt_wdata  = load_format(rdata_p1, lane_p0, byte_p0);
          nxt_bwr    = base_wb_p0 && !kill;
          nxt_bnum   = rn_p0;
          nxt_bdata  = base_data_p0;
          nxt_pc     = pc_p0;
          nxt_insn   = insn_p0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, kill flag and registered bus request
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q   <= IDLE;
      kill_p0   <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 32'h0;
      bus_be    <= 4'h0;
    end else begin
      state_q <= state_d;
      if (cap_ctx) begin
        kill_p0 <= 1'b0;
      end else if ((state_q != IDLE) && flush) begin
        // The access still runs to completion; only its result is dropped.
        kill_p0 <= 1'b1;
      end
      if (cap_ctx) begin
        bus_req   <= 1'b1;
        bus_wr    <= !f_l;
        bus_addr  <= bus_addr_full[ADDR_W-1:0];
        bus_wdata <= f_b ? {4{op2[7:0]}} : op2;
        bus_be    <= byte_enables(acc_addr[1:0], f_b);
      end else if (bus_done) begin
        bus_req <= 1'b0;
      end
    end
  end

  // Access context and load data capture
  always_ff @(posedge clk) begin
    if (cap_ctx) begin
      pc_p0        <= pc;
      insn_p0      <= insn;
      ld_p0        <= f_l;
      byte_p0      <= f_b;
      lane_p0      <= acc_addr[1:0];
      rd_p0        <= insn[15:12];
      rn_p0        <= insn[19:16];
      base_wb_p0   <= base_wb;
      base_data_p0 <= off_addr;
    end
    if (bus_done) begin
      rdata_p1 <= bus_rdata;
    end
  end

  // Output registers towards writeback
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      outbubble      <= 1'b1;
      out_write_reg  <= 1'b0;
      out_write_num  <= 4'h0;
      out_write_data <= 32'h0;
      out_base_wr    <= 1'b0;
      out_base_num   <= 4'h0;
      out_base_data  <= 32'h0;
      outpc          <= 32'h0;
      outinsn        <= 32'h0;
    end else if (out_ld) begin
      outbubble      <= nxt_bubble;
      out_write_reg  <= nxt_wr;
      out_write_num  <= nxt_wnum;
      out_write_data <= nxt_wdata;
      out_base_wr    <= nxt_bwr;
      out_base_num   <= nxt_bnum;
      out_base_data  <= nxt_bdata;
      outpc          <= nxt_pc;
      outinsn        <= nxt_insn;
    end
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes its registered outputs: bubble, pc, insn, op0–op2 and the pending register write.
- Performs ARM single data transfers (LDR/STR, word/byte, pre/post-index, up/down, base writeback) over a simple req/ready data bus.
- Stalls upstream while an access is outstanding.
- Forwards non-memory instructions and their register writes to writeback unchanged, one cycle later.

Parameters:
- ADDR_W, 32, data bus address width; upper bits of the computed address are truncated to this width.

Ports:
clk  in  1  clock
Nrst  in  1  asynchronous active-low reset
stall  in  1  downstream stall; hold all output registers
flush  in  1  kill the instruction currently in this stage
inbubble  in  1  input slot empty
pc  in  32  instruction address
insn  in  32  instruction word
op0  in  32  base register Rn value
op1  in  32  offset (already shifted or immediate)
op2  in  32  store data (Rd value)
write_reg  in  1  execute-stage register write valid
write_num  in  4  execute-stage write register
write_data  in  32  execute-stage write data
outstall  out  1  stall to upstream stages
outbubble  out  1  output slot empty
out_write_reg  out  1  primary register write valid
out_write_num  out  4  primary write register
out_write_data  out  32  primary write data (load result or forwarded)
out_base_wr  out  1  base writeback valid
out_base_num  out  4  base register number
out_base_data  out  32  updated base value
outpc  out  32  registered pc
outinsn  out  32  registered insn
bus_req  out  1  bus request, registered
bus_wr  out  1  1 = store
bus_addr  out  ADDR_W  access address
bus_wdata  out  32  store data
bus_be  out  4  byte enables
bus_ready  in  1  bus accepts/completes the access this cycle
bus_rdata  in  32  load data, valid with bus_ready

Behaviour:
- Decode: memory op when insn[27:26]=01 and not (insn[25] & insn[4]). Fields: P=insn[24], U=insn[23], B=insn[22], W=insn[21], L=insn[20].
- Offset address = U ? op0+op1 : op0-op1, mod 2^32. Access address = P ? offset address : op0.
- Base writeback when (!P | W): out_base_num = insn[19:16], out_base_data = offset address.
- Load destination is insn[15:12]. If a load's destination equals its base register, the load value wins: out_base_wr = 0.
- Byte store: bus_wdata = op2[7:0] replicated to all four lanes; bus_be one-hot at addr[1:0].
- Word store: bus_be = 1111.
- Byte load: zero-extended lane selected by addr[1:0].
- FSM states: IDLE, BUSY, DONE.
- IDLE: a valid memory op (!inbubble & !flush) asserts outstall combinationally and moves to BUSY. bus_req, bus_wr, bus_addr, bus_wdata and bus_be are registered at that edge.
- BUSY: bus_req held high, with all bus outputs stable, until a cycle with bus_ready=1. At that edge: capture bus_rdata, drop bus_req, move to DONE. outstall = 1 throughout BUSY.
- DONE: outstall = stall. When !stall, output registers load the result (outbubble=0; for loads out_write_reg=1, otherwise 0), then return to IDLE. When stall=1, remain in DONE.
- Minimum occupancy for a zero-wait bus: 3 cycles.
- Non-memory instructions and bubbles: registers load on !stall. outbubble = inbubble|flush; write_*, pc and insn pass through; out_base_wr = 0. outstall = stall.
- flush in BUSY: the bus access completes (a request is never withdrawn), but the result is discarded. The DONE load produces outbubble=1 with no writes.
- flush in DONE: same discard behaviour.
- Reset values: state IDLE, bus_req 0, bus_wr 0, outbubble 1. All other output registers 0.
- Reset mid-access: bus_req drops asynchronously; the access is abandoned.

Optional Feature:
- Macro: MEMORY_ROTATE_EN.
- Defined: unaligned word load returns bus_rdata rotated right by 8*addr[1:0] (ARM rotated-load semantics). Unaligned word store drives bus_addr with the low two bits cleared.
- Undefined: all word accesses force bus_addr[1:0]=00 and load data is unrotated. Byte accesses are unaffected in both builds.

Test Plan:
- LDR r1,[r2,#4], op0=0x100, op1=4, bus_ready asserted first BUSY cycle, rdata=0xDEADBEEF -> bus_addr=0x104, bus_req high 1 cycle; out_write_reg=1, num=1, data=0xDEADBEEF; outstall high exactly 2 cycles; out_base_wr=0.
- STRB post-index down, op0=0x203, op1=3, op2=0x1234_56AB, ready delayed 3 cycles -> bus_addr=0x203, be=1000, wdata=0xABABABAB held stable 4 cycles; out_base_wr=1, data=0x200.
- Pre-index writeback LDR [r3,#-8]!, op0=0x40 -> addr 0x38; base write r3=0x38 together with load write.
- flush asserted during BUSY -> bus transfer completes; outbubble=1, no register writes.
- ADD passthrough with write_reg=1 num=5 data=7, then stall for 2 cycles -> outputs update once, held under stall, outstall mirrors stall.
- MEMORY_ROTATE_EN defined, LDR at 0x101, rdata=0x11223344 -> data 0x44112233 and bus_addr=0x100. Undefined -> data 0x11223344.
